// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet transmit types and default constants
package eth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XMIT  = 2'd2,
    IFG   = 2'd3
  } tx_arb_state_t;

  localparam int ETH_IFG_CYCLES       = 12;
  localparam int ETH_TX_START_TIMEOUT = 64;

  // Raise ETH_TX_NUM_SRC/ETH_TX_SRC_W together to add a transmit source.
  localparam int ETH_TX_NUM_SRC = 2;
  localparam int ETH_TX_SRC_W   = 1;

  typedef logic [ETH_TX_SRC_W-1:0] tx_src_t;

  localparam tx_src_t SRC_ARP = 1'b0;
  localparam tx_src_t SRC_UDP = 1'b1;

endpackage

// File: rtl/eth_tx_arbiter.sv
// rtl/eth_tx_arbiter.sv - GMII transmit port arbiter for the ARP and UDP engines
// Grants one source at a time, forwards its stream one register late, enforces the inter-frame gap.
module eth_tx_arbiter
  import eth_pkg::*;
#(
  parameter int IFG_CYCLES    = ETH_IFG_CYCLES,
  parameter int START_TIMEOUT = ETH_TX_START_TIMEOUT,
  parameter int ARP_PRIORITY  = 1
) (
  input  logic       gmii_txc,
  input  logic       rst_n,
  input  logic       arp_req,
  output logic       arp_gnt,
  input  logic       arp_tx_en,
  input  logic [7:0] arp_txd,
  input  logic       udp_req,
  output logic       udp_gnt,
  input  logic       udp_tx_en,
  input  logic [7:0] udp_txd,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       busy,
  output logic       timeout_pulse
);

  localparam int NSRC = ETH_TX_NUM_SRC;

  if (IFG_CYCLES < 1 || IFG_CYCLES > 255 || START_TIMEOUT < 1 || START_TIMEOUT > 255) begin : g_param_check
    $error("eth_tx_arbiter: IFG_CYCLES and START_TIMEOUT must be in 1..255");
  end

  logic [NSRC-1:0] req_vec;
  logic [NSRC-1:0] tx_en_vec;
  logic [7:0]      txd_arr [NSRC];

  assign req_vec[SRC_ARP]   = arp_req;
  assign req_vec[SRC_UDP]   = udp_req;
  assign tx_en_vec[SRC_ARP] = arp_tx_en;
  assign tx_en_vec[SRC_UDP] = udp_tx_en;
  assign txd_arr[SRC_ARP]   = arp_txd;
  assign txd_arr[SRC_UDP]   = udp_txd;

  tx_arb_state_t   state_q;
  logic [7:0]      cnt_q;
  tx_src_t         win_q;
  tx_src_t         last_q;
  logic [NSRC-1:0] gnt_q;
  logic            tx_en_q;
  logic [7:0]      txd_q;
  logic            timeout_q;

  logic       win_req;
  logic       win_tx_en;
  logic [7:0] win_txd;
  logic [7:0] cnt_inc;
  tx_src_t    pick_src;

  assign win_req   = req_vec[win_q];
  assign win_tx_en = tx_en_vec[win_q];
  assign win_txd   = txd_arr[win_q];
  assign cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  // Descending scan: the last hit is the highest-priority requester.
  always_comb begin
    pick_src = SRC_ARP;
    if (ARP_PRIORITY != 0) begin
      for (int k = NSRC - 1; k >= 0; k--) begin
        if (req_vec[tx_src_t'(k)]) pick_src = tx_src_t'(k);
      end
    end else begin
      for (int k = NSRC; k >= 1; k--) begin
        if (req_vec[tx_src_t'((int'(last_q) + k) % NSRC)]) begin
          pick_src = tx_src_t'((int'(last_q) + k) % NSRC);
        end
      end
    end
  end

  always_ff @(posedge gmii_txc or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      win_q     <= SRC_ARP;
      last_q    <= SRC_UDP;
      gnt_q     <= '0;
      tx_en_q   <= 1'b0;
      txd_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req_vec) begin
            win_q   <= pick_src;
            gnt_q   <= {{(NSRC-1){1'b0}}, 1'b1} << pick_src;
            cnt_q   <= 8'd0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (win_tx_en) begin
            tx_en_q <= 1'b1;
            txd_q   <= win_txd;
            state_q <= XMIT;
          end else if (!win_req) begin
            gnt_q   <= '0;
            state_q <= IDLE;
          end else if (cnt_q == 8'(START_TIMEOUT - 1)) begin
            gnt_q     <= '0;
            timeout_q <= 1'b1;
            cnt_q     <= 8'd0;
            state_q   <= IFG;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        XMIT: begin
          // Request level is ignored here; only tx_en falling closes the frame.
          if (win_tx_en) begin
            tx_en_q <= 1'b1;
            txd_q   <= win_txd;
          end else begin
            tx_en_q <= 1'b0;
            txd_q   <= 8'd0;
            gnt_q   <= '0;
            cnt_q   <= 8'd0;
            last_q  <= win_q;
            state_q <= IFG;
          end
        end
        IFG: begin
          if (cnt_q == 8'(IFG_CYCLES - 1)) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign arp_gnt       = gnt_q[SRC_ARP];
  assign udp_gnt       = gnt_q[SRC_UDP];
  assign gmii_tx_en    = tx_en_q;
  assign gmii_txd      = txd_q;
  assign busy          = (state_q != IDLE);
  assign timeout_pulse = timeout_q;

endmodule
